// File: rtl/dsp_top.sv
// dsp_top: ADC burst detector.
// Synchronises an asynchronous ADC interface (ADC_CLK treated as data) into
// CLK_100MHz. It captures one sample per ADC_CLK period on the synchronised
// falling edge and keeps a 4-sample running average per burst. DETECTED is a
// sticky flag that is set when the average exceeds DETECTION_THRESHOLD.
//
// Ports:
//   CLK_100MHz          system clock, rising edge
//   SRESET_n            asynchronous active-low reset
//   ADC_CLK             ADC sample clock, sampled as data
//   ADC_OE_n            ADC output enable, low = burst active
//   ADC_OF              ADC overflow, saturates the sample to full scale
//   ADC_DATA[11:0]      unsigned ADC sample
//   DETECTION_THRESHOLD quasi-static unsigned threshold
//   DETECTED            registered detection flag, sticky until next burst start
module dsp_top (
    input  logic        CLK_100MHz,
    input  logic        SRESET_n,
    input  logic        ADC_CLK,
    input  logic        ADC_OE_n,
    input  logic        ADC_OF,
    input  logic [11:0] ADC_DATA,
    input  logic [11:0] DETECTION_THRESHOLD,
    output logic        DETECTED
);

    localparam int unsigned DW  = 12;
    localparam int unsigned SW  = 14;
    localparam int unsigned WIN = 4;
    localparam int unsigned FW  = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    logic          clk_s1, clk_s2, clk_s3;
    logic          oe_n_s1, oe_n_s2;
    logic          of_s1, of_s2;
    logic [DW-1:0] data_s1, data_s2;

    state_t        state_q, state_d;
    logic          strobe_c, capture_c, burst_start_c;
    logic [DW-1:0] sample_c;
    logic [FW-1:0] fill_next_c;

    logic [WIN-1:0][DW-1:0] win_q;
    logic [FW-1:0] fill_q;
    logic          upd_q, clr_q, full_q;
    logic [DW-1:0] new_q, old_q;
    logic [SW-1:0] sum_q;
    logic          avg_vld_q;
    logic [DW-1:0] avg_c;

    // Two-flop synchroniser for all ADC signals, plus a third flop on ADC_CLK for edge detection
    always_ff @(posedge CLK_100MHz or negedge SRESET_n) begin
        if (!SRESET_n) begin
            clk_s1  <= 1'b0;
            clk_s2  <= 1'b0;
            clk_s3  <= 1'b0;
            oe_n_s1 <= 1'b0;
            oe_n_s2 <= 1'b0;
            of_s1   <= 1'b0;
            of_s2   <= 1'b0;
            data_s1 <= '0;
            data_s2 <= '0;
        end else begin
            clk_s1  <= ADC_CLK;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            oe_n_s1 <= ADC_OE_n;
            oe_n_s2 <= oe_n_s1;
            of_s1   <= ADC_OF;
            of_s2   <= of_s1;
            data_s1 <= ADC_DATA;
            data_s2 <= data_s1;
        end
    end

    // Falling edge of the synchronised ADC_CLK: the data is stable mid-period
    assign strobe_c = clk_s3 & ~clk_s2;
    assign sample_c = of_s2 ? {DW{1'b1}} : data_s2;

    // Burst state register
    always_ff @(posedge CLK_100MHz or negedge SRESET_n) begin
        if (!SRESET_n) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // Burst tracking: OE_n is only evaluated on strobes
    always_comb begin
        state_d       = state_q;
        capture_c     = 1'b0;
        burst_start_c = 1'b0;
        if (strobe_c) begin
            if (!oe_n_s2) begin
                capture_c     = 1'b1;
                burst_start_c = (state_q == ST_IDLE);
                state_d       = ST_BURST;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    assign fill_next_c = burst_start_c           ? FW'(1) :
                         (fill_q == FW'(WIN))    ? fill_q :
                                                   fill_q + FW'(1);

    // Capture stage: shift the window and hand new/oldest samples to the sum stage
    always_ff @(posedge CLK_100MHz or negedge SRESET_n) begin
        if (!SRESET_n) begin
            win_q  <= '0;
            fill_q <= '0;
            upd_q  <= 1'b0;
            clr_q  <= 1'b0;
            full_q <= 1'b0;
            new_q  <= '0;
            old_q  <= '0;
        end else begin
            upd_q <= capture_c;
            if (capture_c) begin
                new_q  <= sample_c;
                old_q  <= burst_start_c ? '0 : win_q[WIN-1];
                clr_q  <= burst_start_c;
                full_q <= (fill_next_c == FW'(WIN));
                fill_q <= fill_next_c;
                win_q[0] <= sample_c;
                for (int i = 1; i < int'(WIN); i++) begin
                    win_q[i] <= burst_start_c ? '0 : win_q[i-1];
                end
            end
        end
    end

    // Sum stage: the burst's first sample restarts the running sum
    always_ff @(posedge CLK_100MHz or negedge SRESET_n) begin
        if (!SRESET_n) begin
            sum_q     <= '0;
            avg_vld_q <= 1'b0;
        end else begin
            avg_vld_q <= upd_q & full_q;
            if (upd_q) begin
                sum_q <= clr_q ? SW'(new_q) : sum_q + SW'(new_q) - SW'(old_q);
            end
        end
    end

    assign avg_c = sum_q[SW-1:2];

    // Detection flag: burst start clears, and clearing has priority over setting
    always_ff @(posedge CLK_100MHz or negedge SRESET_n) begin
        if (!SRESET_n) begin
            DETECTED <= 1'b0;
        end else if (burst_start_c) begin
            DETECTED <= 1'b0;
        end else if (avg_vld_q && (avg_c > DETECTION_THRESHOLD)) begin
            DETECTED <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dsp_top.sv
// Directed testbench for dsp_top. The ADC clock runs at 3 system cycles per
// period (2 high, 1 low) and is driven on the falling system edge. With that
// timing, the capture edge is the 3rd rising edge after ADC_CLK falls, and
// DETECTED updates on the 5th rising edge.
module tb_dsp_top;

    logic        CLK_100MHz;
    logic        SRESET_n;
    logic        ADC_CLK;
    logic        ADC_OE_n;
    logic        ADC_OF;
    logic [11:0] ADC_DATA;
    logic [11:0] DETECTION_THRESHOLD;
    logic        DETECTED;

    int n_checks = 0;
    int n_errors = 0;

    dsp_top dut (
        .CLK_100MHz          (CLK_100MHz),
        .SRESET_n            (SRESET_n),
        .ADC_CLK             (ADC_CLK),
        .ADC_OE_n            (ADC_OE_n),
        .ADC_OF              (ADC_OF),
        .ADC_DATA            (ADC_DATA),
        .DETECTION_THRESHOLD (DETECTION_THRESHOLD),
        .DETECTED            (DETECTED)
    );

    initial begin
        CLK_100MHz = 1'b0;
        forever #5 CLK_100MHz = ~CLK_100MHz;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One ADC period; returns right after ADC_CLK falls
    task automatic adc_cycle(input logic oe_n, input logic of, input logic [11:0] data);
        @(negedge CLK_100MHz);
        ADC_CLK  = 1'b1;
        ADC_OE_n = oe_n;
        ADC_OF   = of;
        ADC_DATA = data;
        @(negedge CLK_100MHz);
        @(negedge CLK_100MHz);
        ADC_CLK = 1'b0;
    endtask

    task automatic burst(input int n, input logic of, input logic [11:0] data);
        for (int i = 0; i < n; i++) adc_cycle(1'b0, of, data);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) adc_cycle(1'b1, 1'b0, 12'h000);
    endtask

    // Wait until the last capture has reached DETECTED
    task automatic settle();
        repeat (5) @(posedge CLK_100MHz);
        #1;
    endtask

    initial begin
        SRESET_n            = 1'b0;
        ADC_CLK             = 1'b0;
        ADC_OE_n            = 1'b1;
        ADC_OF              = 1'b0;
        ADC_DATA            = 12'h000;
        DETECTION_THRESHOLD = 12'h000;
        repeat (3) @(posedge CLK_100MHz);
        #1;
        check("reset", DETECTED, 1'b0);
        @(negedge CLK_100MHz);
        SRESET_n = 1'b1;

        // 8 x 0x100 against 0x0FF: exact latency after the 4th capture
        DETECTION_THRESHOLD = 12'h0FF;
        burst(3, 1'b0, 12'h100);
        settle();
        check("t1_pre4", DETECTED, 1'b0);
        adc_cycle(1'b0, 1'b0, 12'h100);
        repeat (3) @(posedge CLK_100MHz);
        #1;
        check("t1_cap", DETECTED, 1'b0);
        @(posedge CLK_100MHz);
        #1;
        check("t1_cap_p1", DETECTED, 1'b0);
        @(posedge CLK_100MHz);
        #1;
        check("t1_cap_p2", DETECTED, 1'b1);
        burst(4, 1'b0, 12'h100);
        settle();
        check("t1_hold", DETECTED, 1'b1);

        // Equality does not detect
        gap(2);
        DETECTION_THRESHOLD = 12'h100;
        adc_cycle(1'b0, 1'b0, 12'h100);
        settle();
        check("t2_clear", DETECTED, 1'b0);
        burst(7, 1'b0, 12'h100);
        settle();
        check("t2_equal", DETECTED, 1'b0);

        // 0,0,0,0x3FC gives an average of 0x0FF, which is above 0x0FE
        gap(2);
        DETECTION_THRESHOLD = 12'h0FE;
        burst(3, 1'b0, 12'h000);
        settle();
        check("t3_pre4", DETECTED, 1'b0);
        adc_cycle(1'b0, 1'b0, 12'h3FC);
        settle();
        check("t3_avg0ff", DETECTED, 1'b1);

        // 3-sample bursts never detect, even at full scale with a zero threshold
        gap(2);
        DETECTION_THRESHOLD = 12'h000;
        burst(3, 1'b0, 12'hFFF);
        settle();
        check("short_a", DETECTED, 1'b0);
        gap(2);
        burst(3, 1'b0, 12'hFFF);
        gap(2);
        settle();
        check("short_b", DETECTED, 1'b0);

        // Overflow saturates the sample to 0xFFF
        gap(2);
        DETECTION_THRESHOLD = 12'hFFE;
        burst(3, 1'b1, 12'h000);
        settle();
        check("t4_pre4", DETECTED, 1'b0);
        adc_cycle(1'b0, 1'b1, 12'h000);
        settle();
        check("t4_ovf", DETECTED, 1'b1);

        // Detection held through a 100-cycle gap, cleared at the next burst's first capture
        gap(2);
        DETECTION_THRESHOLD = 12'h0FF;
        burst(4, 1'b0, 12'hFFF);
        settle();
        check("t5_b1", DETECTED, 1'b1);
        gap(50);
        check("t5_gap_mid", DETECTED, 1'b1);
        gap(50);
        check("t5_gap_end", DETECTED, 1'b1);
        adc_cycle(1'b0, 1'b0, 12'h000);
        repeat (2) @(posedge CLK_100MHz);
        #1;
        check("t5_pre_cap", DETECTED, 1'b1);
        @(posedge CLK_100MHz);
        #1;
        check("t5_cap_clr", DETECTED, 1'b0);
        burst(7, 1'b0, 12'h000);
        settle();
        check("t5_b2", DETECTED, 1'b0);

        // Asynchronous reset mid-burst, then 4 fresh captures are needed
        gap(2);
        DETECTION_THRESHOLD = 12'h000;
        burst(4, 1'b0, 12'h010);
        settle();
        check("t6_det", DETECTED, 1'b1);
        burst(2, 1'b0, 12'h010);
        settle();
        #2;
        SRESET_n = 1'b0;
        #1;
        check("t6_async_rst", DETECTED, 1'b0);
        repeat (2) @(posedge CLK_100MHz);
        @(negedge CLK_100MHz);
        SRESET_n = 1'b1;
        burst(3, 1'b0, 12'h010);
        settle();
        check("t6_post3", DETECTED, 1'b0);
        adc_cycle(1'b0, 1'b0, 12'h010);
        settle();
        check("t6_post4", DETECTED, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
